// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: shared router types (port_t, position_t), port counts and round-robin index wrap helper
package switch_allocator_pkg;
  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    UP    = 3'd4,
    DOWN  = 3'd5,
    LOCAL = 3'd6
  } port_t;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } position_t;
  localparam int NUM_IN_PORTS  = 6;
  localparam int NUM_OUT_PORTS = 7;
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    return 3'(s >= NUM_IN_PORTS ? s - NUM_IN_PORTS : s);
  endfunction
endpackage

// File: rtl/switch_allocator_rr_lock_arbiter.sv
// rr_lock_arbiter: per-output round-robin pick + owner lock FSM; in clk/reset/cand/release_lock, out locked/owner
module rr_lock_arbiter
  import switch_allocator_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN_PORTS-1:0] cand,
  input  logic                    release_lock,
  output logic                    locked,
  output logic [2:0]              owner
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state;
  logic [2:0] rr_ptr, pick;
  logic       pick_valid;
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_IN_PORTS - 1; k >= 0; k--) begin
      if (cand[wrap_add(rr_ptr, k)]) begin
        pick       = wrap_add(rr_ptr, k);
        pick_valid = 1'b1;
      end
    end
  end
  assign locked = state == LOCKED;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (state == IDLE) begin
      if (pick_valid) begin
        state <= LOCKED;
        owner <= pick;
      end
    end else if (release_lock) begin
      state  <= IDLE;
      rr_ptr <= wrap_add(owner, 1);
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: wormhole switch allocator; in req/tail/dir_in per input, ready per output, up/down_faulty; out grant per input, valid/sel per output, drop
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter bit FAULT_DROP = 1'b0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  north_req,
  input  logic  south_req,
  input  logic  east_req,
  input  logic  west_req,
  input  logic  up_req,
  input  logic  down_req,
  input  logic  north_tail,
  input  logic  south_tail,
  input  logic  east_tail,
  input  logic  west_tail,
  input  logic  up_tail,
  input  logic  down_tail,
  input  port_t north_dir_in,
  input  port_t south_dir_in,
  input  port_t east_dir_in,
  input  port_t west_dir_in,
  input  port_t up_dir_in,
  input  port_t down_dir_in,
  input  logic  north_ready,
  input  logic  south_ready,
  input  logic  east_ready,
  input  logic  west_ready,
  input  logic  up_ready,
  input  logic  down_ready,
  input  logic  local_ready,
  input  logic  up_faulty,
  input  logic  down_faulty,
  output logic  north_grant,
  output logic  south_grant,
  output logic  east_grant,
  output logic  west_grant,
  output logic  up_grant,
  output logic  down_grant,
  output logic  north_valid,
  output logic  south_valid,
  output logic  east_valid,
  output logic  west_valid,
  output logic  up_valid,
  output logic  down_valid,
  output logic  local_valid,
  output port_t north_sel,
  output port_t south_sel,
  output port_t east_sel,
  output port_t west_sel,
  output port_t up_sel,
  output port_t down_sel,
  output port_t local_sel,
  output logic  drop
);
  logic [NUM_IN_PORTS-1:0]  req, tail, busy, grant;
  logic [NUM_OUT_PORTS-1:0] ready, faulty, locked, own_req, own_tail, out_grant, rel, valid;
  logic [NUM_IN_PORTS-1:0]  cand [NUM_OUT_PORTS];
  logic [2:0]               owner [NUM_OUT_PORTS];
  port_t                    dir [NUM_IN_PORTS];
  port_t                    sel [NUM_OUT_PORTS];
  assign req    = {down_req, up_req, west_req, east_req, south_req, north_req};
  assign tail   = {down_tail, up_tail, west_tail, east_tail, south_tail, north_tail};
  assign ready  = {local_ready, down_ready, up_ready, west_ready, east_ready, south_ready, north_ready};
  assign faulty = {1'b0, down_faulty, up_faulty, 4'b0000};
  assign dir[0] = north_dir_in;
  assign dir[1] = south_dir_in;
  assign dir[2] = east_dir_in;
  assign dir[3] = west_dir_in;
  assign dir[4] = up_dir_in;
  assign dir[5] = down_dir_in;
  always_comb begin
    busy = '0;
    for (int o = 0; o < NUM_OUT_PORTS; o++)
      for (int i = 0; i < NUM_IN_PORTS; i++)
        if (locked[o] && owner[o] == 3'(i)) busy[i] = 1'b1;
  end
  // An input still holding any output (including one it releases this cycle) may not bid elsewhere.
  always_comb begin
    for (int o = 0; o < NUM_OUT_PORTS; o++)
      for (int i = 0; i < NUM_IN_PORTS; i++)
        cand[o][i] = req[i] && dir[i] == port_t'(o) && !busy[i] && !faulty[o];
  end
  // A faulty locked output either stalls or, in drop mode, drains flits regardless of credit.
  always_comb begin
    for (int o = 0; o < NUM_OUT_PORTS; o++) begin
      own_req[o]   = req[owner[o]];
      own_tail[o]  = tail[owner[o]];
      out_grant[o] = !reset && locked[o] && own_req[o] && (faulty[o] ? FAULT_DROP : ready[o]);
    end
  end
  assign rel   = out_grant & own_tail;
  assign valid = out_grant & ~faulty;
  assign drop  = |(out_grant & faulty);
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_OUT_PORTS; o++)
      for (int i = 0; i < NUM_IN_PORTS; i++)
        if (out_grant[o] && owner[o] == 3'(i)) grant[i] = 1'b1;
  end
  for (genvar o = 0; o < NUM_OUT_PORTS; o++) begin : g_out
    rr_lock_arbiter u_arb (
      .clk          (clk),
      .reset        (reset),
      .cand         (cand[o]),
      .release_lock (rel[o]),
      .locked       (locked[o]),
      .owner        (owner[o])
    );
    assign sel[o] = locked[o] ? port_t'(owner[o]) : NORTH;
  end
  assign {down_grant, up_grant, west_grant, east_grant, south_grant, north_grant} = grant;
  assign {local_valid, down_valid, up_valid, west_valid, east_valid, south_valid, north_valid} = valid;
  assign north_sel = sel[0];
  assign south_sel = sel[1];
  assign east_sel  = sel[2];
  assign west_sel  = sel[3];
  assign up_sel    = sel[4];
  assign down_sel  = sel[5];
  assign local_sel = sel[6];
endmodule
